mc_control_fsm: RTL and testbench

Parametrised control unit for the multicycle MIPS datapath. It replaces the single-cycle opcode decoder with a Moore state machine that sequences Fetch, Decode, Execute, Memory and Writeback over several cycles. It adds optional BNE/ORI support, a memory-ready stall handshake, an illegal-opcode trap and a retired-instruction counter. It sits between the instruction register's `op` field and the multicycle datapath enables.

---
 rtl/mc_ctrl_pkg.sv | 87 ++++++++
 rtl/mc_ctrl_outdec.sv | 108 ++++++++++
 rtl/mc_control_fsm.sv | 174 +++++++++++++++++
 tb/tb_mc_control_fsm.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mc_ctrl_pkg
// Description : Shared types and constants for the multicycle MIPS control
//               unit: state encoding, opcodes, datapath select codes and the
//               packed control-word layout.
// Revision    : 1.0 - initial release
// ============================================================================
package mc_ctrl_pkg;

  // Controller states. Encodings are fixed because external debug logic
  // and test benches observe them.
  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTE  = 4'd6,
    S_ALUWB    = 4'd7,
    S_BRANCH   = 4'd8,
    S_ADDIEX   = 4'd9,
    S_IMMWB    = 4'd10,
    S_JUMP     = 4'd11,
    S_ORIEX    = 4'd12,
    S_TRAP     = 4'd15
  } state_t;

  // Opcodes recognised by the decoder
  localparam logic [5:0] c_op_rtype = 6'b000000;
  localparam logic [5:0] c_op_lw    = 6'b100011;
  localparam logic [5:0] c_op_sw    = 6'b101011;
  localparam logic [5:0] c_op_beq   = 6'b000100;
  localparam logic [5:0] c_op_bne   = 6'b000101;
  localparam logic [5:0] c_op_addi  = 6'b001000;
  localparam logic [5:0] c_op_ori   = 6'b001101;
  localparam logic [5:0] c_op_j     = 6'b000010;

  // ALU operation class handed to the ALU decoder
  localparam logic [1:0] c_aluop_add   = 2'b00;
  localparam logic [1:0] c_aluop_sub   = 2'b01;
  localparam logic [1:0] c_aluop_funct = 2'b10;
  localparam logic [1:0] c_aluop_or    = 2'b11;

  // ALU B-operand source
  localparam logic [1:0] c_srcb_reg  = 2'b00;
  localparam logic [1:0] c_srcb_four = 2'b01;
  localparam logic [1:0] c_srcb_imm  = 2'b10;
  localparam logic [1:0] c_srcb_boff = 2'b11;

  // Next-PC source
  localparam logic [1:0] c_pcsrc_alu    = 2'b00;
  localparam logic [1:0] c_pcsrc_aluout = 2'b01;
  localparam logic [1:0] c_pcsrc_jump   = 2'b10;

  // Full control word produced by the output decoder
  typedef struct packed {
    logic       pcwrite;
    logic       memwrite;
    logic       irwrite;
    logic       regwrite;
    logic       alusrca;
    logic       branch;
    logic       branch_ne;
    logic       iord;
    logic       memtoreg;
    logic       regdst;
    logic       zeroext;
    logic       illegal;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic [1:0] aluop;
  } ctrl_t;

  // True for the final state of every instruction that completes normally;
  // leaving one of these states towards FETCH retires an instruction.
  function automatic logic retires_from(input state_t s);
    case (s)
      S_MEMWB, S_MEMWRITE, S_ALUWB,
      S_BRANCH, S_IMMWB, S_JUMP: retires_from = 1'b1;
      default:                   retires_from = 1'b0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/mc_ctrl_outdec.sv
`default_nettype none
// ============================================================================
// Module      : mc_ctrl_outdec
// Description : Combinational state-to-controls decoder for the multicycle
//               MIPS controller. Pure Moore decode except that the FETCH
//               write enables are qualified by the memory-ready handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module mc_ctrl_outdec
  import mc_ctrl_pkg::*;
(
  input  logic [3:0]                state,
  input  logic                      mem_rdy,
  input  logic                      is_bne,
  output logic [$bits(ctrl_t)-1:0]  ctrl
);

  ctrl_t w_c;

  // Decode the current state into the datapath control word
  always_comb begin
    w_c = '0;
    case (state_t'(state))
      S_FETCH: begin
        // IR and PC are written only in the cycle the fetch completes, so
        // a stalled fetch never advances the PC twice.
        w_c.iord    = 1'b0;
        w_c.alusrca = 1'b0;
        w_c.alusrcb = c_srcb_four;
        w_c.aluop   = c_aluop_add;
        w_c.pcsrc   = c_pcsrc_alu;
        w_c.irwrite = mem_rdy;
        w_c.pcwrite = mem_rdy;
      end
      S_DECODE: begin
        // Pre-compute the branch target while the register file is read
        w_c.alusrca = 1'b0;
        w_c.alusrcb = c_srcb_boff;
        w_c.aluop   = c_aluop_add;
      end
      S_MEMADR: begin
        w_c.alusrca = 1'b1;
        w_c.alusrcb = c_srcb_imm;
        w_c.aluop   = c_aluop_add;
      end
      S_MEMREAD: begin
        w_c.iord = 1'b1;
      end
      S_MEMWB: begin
        w_c.regdst   = 1'b0;
        w_c.memtoreg = 1'b1;
        w_c.regwrite = 1'b1;
      end
      S_MEMWRITE: begin
        // Write strobe is held for the whole state, including stall cycles
        w_c.iord     = 1'b1;
        w_c.memwrite = 1'b1;
      end
      S_EXECUTE: begin
        w_c.alusrca = 1'b1;
        w_c.alusrcb = c_srcb_reg;
        w_c.aluop   = c_aluop_funct;
      end
      S_ALUWB: begin
        w_c.regdst   = 1'b1;
        w_c.regwrite = 1'b1;
      end
      S_BRANCH: begin
        w_c.alusrca   = 1'b1;
        w_c.alusrcb   = c_srcb_reg;
        w_c.aluop     = c_aluop_sub;
        w_c.pcsrc     = c_pcsrc_aluout;
        w_c.branch    = ~is_bne;
        w_c.branch_ne = is_bne;
      end
      S_ADDIEX: begin
        w_c.alusrca = 1'b1;
        w_c.alusrcb = c_srcb_imm;
        w_c.aluop   = c_aluop_add;
      end
      S_ORIEX: begin
        w_c.alusrca = 1'b1;
        w_c.alusrcb = c_srcb_imm;
        w_c.aluop   = c_aluop_or;
        w_c.zeroext = 1'b1;
      end
      S_IMMWB: begin
        w_c.regdst   = 1'b0;
        w_c.memtoreg = 1'b0;
        w_c.regwrite = 1'b1;
      end
      S_JUMP: begin
        w_c.pcsrc   = c_pcsrc_jump;
        w_c.pcwrite = 1'b1;
      end
      S_TRAP: begin
        w_c.illegal = 1'b1;
      end
      default: begin
        w_c = '0;
      end
    endcase
  end

  assign ctrl = w_c;

endmodule
`default_nettype wire

// File: rtl/mc_control_fsm.sv
`default_nettype none
// ============================================================================
// Module      : mc_control_fsm
// Description : Multicycle MIPS control unit. Moore FSM sequencing fetch,
//               decode, execute, memory and writeback, with optional BNE/ORI,
//               memory-ready stalls, illegal-opcode trap and a retired
//               instruction counter.
// Revision    : 1.0 - initial release
// ============================================================================
module mc_control_fsm
  import mc_ctrl_pkg::*;
#(
  parameter bit EXT_BNE         = 1'b1,
  parameter bit EXT_ORI         = 1'b1,
  parameter bit MEM_WAIT        = 1'b0,
  parameter bit TRAP_ON_ILLEGAL = 1'b1,
  parameter int CNT_W           = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       op,
  input  logic             mem_ready,
  output logic             pcwrite,
  output logic             memwrite,
  output logic             irwrite,
  output logic             regwrite,
  output logic             alusrca,
  output logic             branch,
  output logic             branch_ne,
  output logic             iord,
  output logic             memtoreg,
  output logic             regdst,
  output logic             zeroext,
  output logic [1:0]       alusrcb,
  output logic [1:0]       pcsrc,
  output logic [1:0]       aluop,
  output logic             illegal,
  output logic [CNT_W-1:0] retired
);

  state_t           r_state;
  state_t           w_next;
  state_t           w_bad_next;
  logic             w_mem_rdy;
  logic             r_is_bne;
  logic [CNT_W-1:0] r_retired;
  ctrl_t            w_ctrl;

  // Without wait support the memory is assumed to answer in one cycle
  assign w_mem_rdy = MEM_WAIT ? mem_ready : 1'b1;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic: decode dispatch, memory stalls and trap handling
  always_comb begin
    w_next = r_state;
    if (TRAP_ON_ILLEGAL) begin
      w_bad_next = S_TRAP;
    end else begin
      w_bad_next = S_FETCH;
    end
    case (r_state)
      S_FETCH: begin
        if (w_mem_rdy) begin
          w_next = S_DECODE;
        end
      end
      S_DECODE: begin
        case (op)
          c_op_lw, c_op_sw: w_next = S_MEMADR;
          c_op_rtype:       w_next = S_EXECUTE;
          c_op_beq:         w_next = S_BRANCH;
          c_op_bne: begin
            if (EXT_BNE) begin
              w_next = S_BRANCH;
            end else begin
              w_next = w_bad_next;
            end
          end
          c_op_addi:        w_next = S_ADDIEX;
          c_op_ori: begin
            if (EXT_ORI) begin
              w_next = S_ORIEX;
            end else begin
              w_next = w_bad_next;
            end
          end
          c_op_j:           w_next = S_JUMP;
          default:          w_next = w_bad_next;
        endcase
      end
      S_MEMADR: begin
        if (op == c_op_lw) begin
          w_next = S_MEMREAD;
        end else begin
          w_next = S_MEMWRITE;
        end
      end
      S_MEMREAD: begin
        if (w_mem_rdy) begin
          w_next = S_MEMWB;
        end
      end
      S_MEMWRITE: begin
        if (w_mem_rdy) begin
          w_next = S_FETCH;
        end
      end
      S_EXECUTE: w_next = S_ALUWB;
      S_ADDIEX:  w_next = S_IMMWB;
      S_ORIEX:   w_next = S_IMMWB;
      S_MEMWB, S_ALUWB, S_BRANCH, S_IMMWB, S_JUMP: begin
        w_next = S_FETCH;
      end
      S_TRAP:    w_next = S_TRAP;
      default:   w_next = S_FETCH;
    endcase
  end

  // Remember which branch flavour was decoded so BRANCH can drive the
  // matching compare enable without re-reading the opcode.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_is_bne <= 1'b0;
    end else if (r_state == S_DECODE) begin
      r_is_bne <= (op == c_op_bne);
    end
  end

  // Count instructions that complete normally; an illegal return does not count
  always_ff @(posedge clk) begin
    if (reset) begin
      r_retired <= '0;
    end else if ((w_next == S_FETCH) && retires_from(r_state)) begin
      r_retired <= r_retired + CNT_W'(1);
    end
  end

  // State-to-controls decode
  mc_ctrl_outdec u_outdec (
    .state   (r_state),
    .mem_rdy (w_mem_rdy),
    .is_bne  (r_is_bne),
    .ctrl    (w_ctrl)
  );

  // Architectural write enables are suppressed while reset is held so an
  // aborted instruction cannot leave a partial write behind.
  assign pcwrite   = w_ctrl.pcwrite  & ~reset;
  assign memwrite  = w_ctrl.memwrite & ~reset;
  assign irwrite   = w_ctrl.irwrite  & ~reset;
  assign regwrite  = w_ctrl.regwrite & ~reset;
  assign alusrca   = w_ctrl.alusrca;
  assign branch    = w_ctrl.branch;
  assign branch_ne = w_ctrl.branch_ne;
  assign iord      = w_ctrl.iord;
  assign memtoreg  = w_ctrl.memtoreg;
  assign regdst    = w_ctrl.regdst;
  assign zeroext   = w_ctrl.zeroext;
  assign alusrcb   = w_ctrl.alusrcb;
  assign pcsrc     = w_ctrl.pcsrc;
  assign aluop     = w_ctrl.aluop;
  assign illegal   = w_ctrl.illegal;
  assign retired   = r_retired;

endmodule
`default_nettype wire

// File: tb/tb_mc_control_fsm.sv
`default_nettype none
// ============================================================================
// Module      : tb_mc_control_fsm
// Description : Scoreboard bench for mc_control_fsm. Three instances cover
//               the parameter variants; directed per-cycle vectors push the
//               expected state and counter into a queue, and a monitor on the
//               falling edge decodes and compares every control output.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mc_control_fsm;

  localparam int c_n = 3;

  // State codes as the controller is expected to sequence them
  localparam logic [3:0] FE = 4'd0,  DE = 4'd1,  MA = 4'd2,  MR = 4'd3;
  localparam logic [3:0] MB = 4'd4,  MW = 4'd5,  EX = 4'd6,  AW = 4'd7;
  localparam logic [3:0] BR = 4'd8,  AI = 4'd9,  IW = 4'd10, JP = 4'd11;
  localparam logic [3:0] OX = 4'd12, TR = 4'd15;

  localparam logic [5:0] LW  = 6'b100011, SW   = 6'b101011, RT  = 6'b000000;
  localparam logic [5:0] BEQ = 6'b000100, BNE  = 6'b000101, ADI = 6'b001000;
  localparam logic [5:0] ORI = 6'b001101, JMP  = 6'b000010, BAD = 6'b111111;

  typedef struct {
    int         idx;
    int         n;
    logic [3:0] st;
    bit         mre;
    bit         rst;
    bit         bne;
    int         ret;
  } exp_t;

  logic        clk = 1'b0;
  logic [5:0]  op_v   [c_n];
  logic        mr_v   [c_n];
  logic        rst_v  [c_n];
  logic [17:0] ctrl_v [c_n];
  logic [31:0] ret_v  [c_n];

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   seq    = 0;

  always #5 clk = ~clk;

  // dut0: defaults; dut1: MEM_WAIT=1, EXT_BNE=0; dut2: no trap, 2-bit counter
  generate
    for (genvar i = 0; i < c_n; i++) begin : g_dut
      localparam int CW = (i == 2) ? 2 : 32;
      logic pcwrite, memwrite, irwrite, regwrite, alusrca, branch, branch_ne;
      logic iord, memtoreg, regdst, zeroext, illegal;
      logic [1:0] alusrcb, pcsrc, aluop;
      logic [CW-1:0] retired;

      mc_control_fsm #(
        .EXT_BNE         (i != 1),
        .EXT_ORI         (1'b1),
        .MEM_WAIT        (i == 1),
        .TRAP_ON_ILLEGAL (i != 2),
        .CNT_W           (CW)
      ) u_dut (
        .clk       (clk),
        .reset     (rst_v[i]),
        .op        (op_v[i]),
        .mem_ready (mr_v[i]),
        .pcwrite   (pcwrite),
        .memwrite  (memwrite),
        .irwrite   (irwrite),
        .regwrite  (regwrite),
        .alusrca   (alusrca),
        .branch    (branch),
        .branch_ne (branch_ne),
        .iord      (iord),
        .memtoreg  (memtoreg),
        .regdst    (regdst),
        .zeroext   (zeroext),
        .alusrcb   (alusrcb),
        .pcsrc     (pcsrc),
        .aluop     (aluop),
        .illegal   (illegal),
        .retired   (retired)
      );

      assign ctrl_v[i] = {pcwrite, memwrite, irwrite, regwrite, alusrca, branch,
                          branch_ne, iord, memtoreg, regdst, zeroext, illegal,
                          alusrcb, pcsrc, aluop};
      assign ret_v[i]  = 32'(retired);
    end
  endgenerate

  // Reference control table, written from the state-by-state output list
  function automatic logic [17:0] exp_ctrl(input logic [3:0] st, input bit mr,
                                           input bit rst, input bit bne);
    logic pcw = 0, mw = 0, irw = 0, rw = 0, sa = 0, br = 0, bn = 0, io = 0;
    logic mtr = 0, rd = 0, ze = 0, ill = 0;
    logic [1:0] sb = 2'b00, ps = 2'b00, ao = 2'b00;
    case (st)
      FE: begin sb = 2'b01; pcw = mr; irw = mr; end
      DE: begin sb = 2'b11; end
      MA: begin sa = 1; sb = 2'b10; end
      MR: begin io = 1; end
      MB: begin mtr = 1; rw = 1; end
      MW: begin io = 1; mw = 1; end
      EX: begin sa = 1; ao = 2'b10; end
      AW: begin rd = 1; rw = 1; end
      BR: begin sa = 1; ao = 2'b01; ps = 2'b01; br = !bne; bn = bne; end
      AI: begin sa = 1; sb = 2'b10; end
      OX: begin sa = 1; sb = 2'b10; ao = 2'b11; ze = 1; end
      IW: begin rw = 1; end
      JP: begin ps = 2'b10; pcw = 1; end
      TR: begin ill = 1; end
      default: ;
    endcase
    if (rst) begin
      pcw = 0; mw = 0; irw = 0; rw = 0;
    end
    return {pcw, mw, irw, rw, sa, br, bn, io, mtr, rd, ze, ill, sb, ps, ao};
  endfunction

  // Monitor: pop one expectation per cycle and compare away from the edge
  always @(negedge clk) begin
    exp_t e;
    logic [17:0] want;
    if (q.size() > 0) begin
      e = q.pop_front();
      want = exp_ctrl(e.st, e.mre, e.rst, e.bne);
      checks++;
      if (ctrl_v[e.idx] !== want) begin
        errors++;
        $display("FAIL ctrl dut%0d step%0d state%0d got %b want %b",
                 e.idx, e.n, e.st, ctrl_v[e.idx], want);
      end
      checks++;
      if (ret_v[e.idx] !== 32'(e.ret)) begin
        errors++;
        $display("FAIL retired dut%0d step%0d got %0d want %0d",
                 e.idx, e.n, ret_v[e.idx], e.ret);
      end
    end
  end

  // One cycle of stimulus for the selected instance; the others sit in reset
  task automatic step(input int idx, input logic [5:0] op, input bit mr,
                      input bit rst, input logic [3:0] st, input bit mre,
                      input bit bne, input int ret);
    exp_t e;
    @(posedge clk);
    #1;
    for (int k = 0; k < c_n; k++) begin
      rst_v[k] = 1'b1;
      op_v[k]  = 6'd0;
      mr_v[k]  = 1'b0;
    end
    op_v[idx]  = op;
    mr_v[idx]  = mr;
    rst_v[idx] = rst;
    e.idx = idx; e.n = seq; e.st = st; e.mre = mre;
    e.rst = rst; e.bne = bne; e.ret = ret;
    q.push_back(e);
    seq++;
  endtask

  initial begin
    for (int k = 0; k < c_n; k++) begin
      rst_v[k] = 1'b1;
      op_v[k]  = 6'd0;
      mr_v[k]  = 1'b0;
    end
    repeat (2) @(posedge clk);

    // dut0: mem_ready held low throughout to show it is ignored
    step(0, LW,  0, 1, FE, 1, 0, 0);   // reset state
    step(0, LW,  0, 0, FE, 1, 0, 0);   // LW: 5 cycles
    step(0, LW,  0, 0, DE, 1, 0, 0);
    step(0, LW,  0, 0, MA, 1, 0, 0);
    step(0, LW,  0, 0, MR, 1, 0, 0);
    step(0, LW,  0, 0, MB, 1, 0, 0);
    step(0, RT,  0, 0, FE, 1, 0, 1);   // R-type
    step(0, RT,  0, 0, DE, 1, 0, 1);
    step(0, RT,  0, 0, EX, 1, 0, 1);
    step(0, RT,  0, 0, AW, 1, 0, 1);
    step(0, BEQ, 0, 0, FE, 1, 0, 2);   // BEQ
    step(0, BEQ, 0, 0, DE, 1, 0, 2);
    step(0, BEQ, 0, 0, BR, 1, 0, 2);
    step(0, BNE, 0, 0, FE, 1, 0, 3);   // BNE
    step(0, BNE, 0, 0, DE, 1, 0, 3);
    step(0, BNE, 0, 0, BR, 1, 1, 3);
    step(0, ORI, 0, 0, FE, 1, 0, 4);   // ORI
    step(0, ORI, 0, 0, DE, 1, 0, 4);
    step(0, ORI, 0, 0, OX, 1, 0, 4);
    step(0, ORI, 0, 0, IW, 1, 0, 4);
    step(0, ADI, 0, 0, FE, 1, 0, 5);   // ADDI
    step(0, ADI, 0, 0, DE, 1, 0, 5);
    step(0, ADI, 0, 0, AI, 1, 0, 5);
    step(0, ADI, 0, 0, IW, 1, 0, 5);
    step(0, JMP, 0, 0, FE, 1, 0, 6);   // J
    step(0, JMP, 0, 0, DE, 1, 0, 6);
    step(0, JMP, 0, 0, JP, 1, 0, 6);
    step(0, BAD, 0, 0, FE, 1, 0, 7);   // illegal -> TRAP
    step(0, BAD, 0, 0, DE, 1, 0, 7);
    for (int k = 0; k < 10; k++) step(0, BAD, 0, 0, TR, 1, 0, 7);
    step(0, BAD, 0, 1, TR, 1, 0, 7);   // reset while trapped
    step(0, BAD, 0, 0, FE, 1, 0, 0);

    // dut1: stalls, reset during MEMREAD stall, BNE disabled
    step(1, SW,  1, 1, FE, 1, 0, 0);
    step(1, SW,  0, 0, FE, 0, 0, 0);   // fetch stall: no PC/IR write
    step(1, SW,  1, 0, FE, 1, 0, 0);
    step(1, SW,  0, 0, DE, 0, 0, 0);
    step(1, SW,  0, 0, MA, 0, 0, 0);
    step(1, SW,  0, 0, MW, 0, 0, 0);
    step(1, SW,  0, 0, MW, 0, 0, 0);
    step(1, SW,  1, 0, MW, 1, 0, 0);
    step(1, LW,  1, 0, FE, 1, 0, 1);
    step(1, LW,  0, 0, DE, 0, 0, 1);
    step(1, LW,  0, 0, MA, 0, 0, 1);
    step(1, LW,  0, 0, MR, 0, 0, 1);
    step(1, LW,  0, 1, MR, 0, 0, 1);   // reset mid-stall
    step(1, BNE, 1, 0, FE, 1, 0, 0);
    step(1, BNE, 0, 0, DE, 0, 0, 0);
    step(1, BNE, 1, 0, TR, 1, 0, 0);
    step(1, BNE, 0, 0, TR, 0, 0, 0);

    // dut2: illegal returns to FETCH, counter wraps at 4
    step(2, BAD, 0, 1, FE, 1, 0, 0);
    step(2, BAD, 0, 0, FE, 1, 0, 0);
    step(2, BAD, 0, 0, DE, 1, 0, 0);
    step(2, JMP, 0, 0, FE, 1, 0, 0);
    for (int j = 0; j < 4; j++) begin
      step(2, JMP, 0, 0, DE, 1, 0, j);
      step(2, JMP, 0, 0, JP, 1, 0, j);
      step(2, JMP, 0, 0, FE, 1, 0, (j + 1) % 4);
    end

    repeat (3) @(posedge clk);
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain pending %0d want 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
